// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end sharing one 8-bit ALU; response tagged with requester id.
// Latency: accept at edge k, rsp_valid from edge k+1; 3 cycles per op, no pipelining.
// Backpressure: rsp_ready low holds the response stable and blocks all new requests.
module alu #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [1:0]   alu_control,
    output logic [N-1:0] result,
    output logic         v,
    output logic         c,
    output logic         neg,
    output logic         z
);
    logic         sub;
    logic [N-1:0] b_m;
    logic [N:0]   sum_ext;
    logic         carry_into_msb;

    always_comb begin
        sub     = (alu_control == 2'b01);
        b_m     = sub ? ~b : b;
        sum_ext = {1'b0, a} + {1'b0, b_m} + {{N{1'b0}}, sub};
        // carry into the MSB recovered from the MSB sum bit and its two addends
        carry_into_msb = sum_ext[N-1] ^ a[N-1] ^ b_m[N-1];
        c   = sum_ext[N];
        v   = sum_ext[N] ^ carry_into_msb;
        neg = sum_ext[N-1];
        z   = (sum_ext[N-1:0] == '0);
        case (alu_control)
            2'b10:   result = a & b;
            2'b11:   result = a | b;
            default: result = sum_ext[N-1:0];
        endcase
    end
endmodule

module alu_arbiter #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [N-1:0] A0,
    input  logic [N-1:0] B0,
    input  logic [1:0]   ALUControl0,
    input  logic [N-1:0] A1,
    input  logic [N-1:0] B1,
    input  logic [1:0]   ALUControl1,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [N-1:0] Result,
    output logic         V,
    output logic         C,
    output logic         Neg,
    output logic         Z
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic         last_grant_q, last_grant_d;
    logic         id_q, id_d;
    logic [N-1:0] op_a_q, op_a_d;
    logic [N-1:0] op_b_q, op_b_d;
    logic [1:0]   op_ctl_q, op_ctl_d;
    logic         rsp_valid_q, rsp_valid_d;
    logic         rsp_id_q, rsp_id_d;
    logic [N-1:0] result_q, result_d;
    logic         v_q, v_d, c_q, c_d, neg_q, neg_d, z_q, z_d;

    logic         grant;
    logic [1:0]   req_ready_c;
    logic [N-1:0] alu_result;
    logic         alu_v, alu_c, alu_neg, alu_z;

    alu #(.N(N)) u_alu (
        .a           (op_a_q),
        .b           (op_b_q),
        .alu_control (op_ctl_q),
        .result      (alu_result),
        .v           (alu_v),
        .c           (alu_c),
        .neg         (alu_neg),
        .z           (alu_z)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_ctl_d     = op_ctl_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        result_d     = result_q;
        v_d          = v_q;
        c_d          = c_q;
        neg_d        = neg_q;
        z_d          = z_q;
        req_ready_c  = 2'b00;
        grant        = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid == 2'b01)      grant = 1'b0;
                else if (req_valid == 2'b10) grant = 1'b1;
                else                         grant = ~last_grant_q;
                // the granted requester is always valid here, so ready implies handshake
                if (|req_valid) begin
                    req_ready_c = grant ? 2'b10 : 2'b01;
                    id_d        = grant;
                    op_a_d      = grant ? A1 : A0;
                    op_b_d      = grant ? B1 : B0;
                    op_ctl_d    = grant ? ALUControl1 : ALUControl0;
                    state_d     = EXEC;
                end
            end
            EXEC: begin
                result_d    = alu_result;
                v_d         = alu_v;
                c_d         = alu_c;
                neg_d       = alu_neg;
                z_d         = alu_z;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d  = 1'b0;
                    last_grant_d = id_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_ctl_q     <= 2'b00;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            result_q     <= '0;
            v_q          <= 1'b0;
            c_q          <= 1'b0;
            neg_q        <= 1'b0;
            z_q          <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_ctl_q     <= op_ctl_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            result_q     <= result_d;
            v_q          <= v_d;
            c_q          <= c_d;
            neg_q        <= neg_d;
            z_q          <= z_d;
        end
    end

    // no grant is offered while reset is held, even though IDLE is combinational
    assign req_ready = reset_n ? req_ready_c : 2'b00;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign Result    = result_q;
    assign V         = v_q;
    assign C         = c_q;
    assign Neg       = neg_q;
    assign Z         = z_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed-vector bench for alu_arbiter: grants, ALU results/flags, backpressure, fairness, reset abort.
module tb_alu_arbiter;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [7:0] A0, B0, A1, B1;
    logic [1:0] ALUControl0, ALUControl1;
    logic       rsp_valid, rsp_ready, rsp_id;
    logic [7:0] Result;
    logic       V, C, Neg, Z;

    int vectors = 0;
    int miscompares = 0;

    alu_arbiter #(.N(8)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .A0          (A0),
        .B0          (B0),
        .ALUControl0 (ALUControl0),
        .A1          (A1),
        .B1          (B1),
        .ALUControl1 (ALUControl1),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .Result      (Result),
        .V           (V),
        .C           (C),
        .Neg         (Neg),
        .Z           (Z)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // flags packed as {V,C,Neg,Z}
    task automatic chk_rsp(input string tag, input logic exp_id, input logic [7:0] exp_res,
                           input logic [3:0] exp_flags);
        chk({tag, "_vld"},   {31'd0, rsp_valid}, 32'd1);
        chk({tag, "_id"},    {31'd0, rsp_id}, {31'd0, exp_id});
        chk({tag, "_res"},   {24'd0, Result}, {24'd0, exp_res});
        chk({tag, "_flags"}, {28'd0, V, C, Neg, Z}, {28'd0, exp_flags});
        chk({tag, "_rdy"},   {30'd0, req_ready}, 32'd0);
    endtask

    // Waits (bounded) for a grant in IDLE, then checks EXEC and first RESP cycle.
    // Returns sampling at the negedge of the first RESP cycle.
    task automatic do_op(input string tag, input logic [1:0] exp_rdy, input logic exp_id,
                         input logic [7:0] exp_res, input logic [3:0] exp_flags);
        @(negedge clk);
        for (int i = 0; i < 8 && req_ready == 2'b00; i++) @(negedge clk);
        chk({tag, "_grant"}, {30'd0, req_ready}, {30'd0, exp_rdy});
        @(negedge clk);
        chk({tag, "_exec_vld"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_exec_rdy"}, {30'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk_rsp(tag, exp_id, exp_res, exp_flags);
    endtask

    initial begin
        reset_n = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        A0 = 8'd100; B0 = 8'd50; ALUControl0 = 2'b00;
        A1 = 8'd5;   B1 = 8'd5;  ALUControl1 = 2'b01;

        // reset state, with requests already pending
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy", {30'd0, req_ready}, 32'd0);
        chk("rst_out", {20'd0, rsp_valid, rsp_id, Result, V, C, Neg, Z}, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // contention after reset: 0 first, then 1
        do_op("add0", 2'b01, 1'b0, 8'h96, 4'b1010);
        do_op("sub1", 2'b10, 1'b1, 8'h00, 4'b0101);
        @(posedge clk); #1;
        req_valid = 2'b10;
        A1 = 8'hF0; B1 = 8'h3C; ALUControl1 = 2'b10;

        // single requester AND; flags come from the sum 0x12C
        do_op("and1", 2'b10, 1'b1, 8'h30, 4'b0100);
        @(posedge clk); #1;
        req_valid = 2'b11;
        rsp_ready = 1'b0;
        A0 = 8'h7F; B0 = 8'h01; ALUControl0 = 2'b00;
        A1 = 8'h03; B1 = 8'h05; ALUControl1 = 2'b01;

        // backpressure: response held 5 cycles with both requesters waiting
        do_op("bp0", 2'b01, 1'b0, 8'h80, 4'b1010);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_rsp("bp_hold", 1'b0, 8'h80, 4'b1010);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        do_op("bp1", 2'b10, 1'b1, 8'hFE, 4'b0010);

        // continuous contention: strict alternation 0,1,0,1,0,1
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) do_op("rr0", 2'b01, 1'b0, 8'h80, 4'b1010);
            else            do_op("rr1", 2'b10, 1'b1, 8'hFE, 4'b0010);
        end

        // reset during EXEC of an OR
        req_valid = 2'b01;
        A0 = 8'h0F; B0 = 8'hF0; ALUControl0 = 2'b11;
        @(negedge clk);
        for (int i = 0; i < 8 && req_ready == 2'b00; i++) @(negedge clk);
        chk("or_grant", {30'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        reset_n = 1'b0;
        req_valid = 2'b00;
        @(negedge clk);
        chk("or_exec_vld", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("abort_out", {20'd0, rsp_valid, rsp_id, Result, V, C, Neg, Z}, 32'd0);
        chk("abort_rdy", {30'd0, req_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_norsp", {31'd0, rsp_valid}, 32'd0);
        end

        // fresh contention after reset grants requester 0 first
        @(posedge clk); #1;
        A0 = 8'd100; B0 = 8'd50; ALUControl0 = 2'b00;
        A1 = 8'd5;   B1 = 8'd5;  ALUControl1 = 2'b01;
        req_valid = 2'b11;
        do_op("post0", 2'b01, 1'b0, 8'h96, 4'b1010);
        do_op("post1", 2'b10, 1'b1, 8'h00, 4'b0101);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Two-requester front end that shares one `ALU` (N-bit; ADD/SUB/AND/OR; V/C/Neg/Z flags) between independent clients.
- Grants access round-robin over a valid/ready handshake and latches the granted operands into the ALU.
- Registers the result and flags, then returns them on a single response channel tagged with the requester ID.
- Sits between the instruction-issue logic of two consumers and the shared datapath ALU, which it instantiates internally.

Parameters:
- N, 8, operand/result width passed to the internal `ALU` instance (the `ALU` datapath is 8-bit; N=8 is the only supported value).

Ports:
- clk  input  1  system clock, rising-edge.
- reset_n  input  1  synchronous, active-low reset.
- req_valid  input  2  per-requester request valid; bit i belongs to requester i.
- req_ready  output  2  per-requester accept; at most one bit high in any cycle.
- A0, B0  input  N each  requester 0 operands.
- ALUControl0  input  2  requester 0 op: 00 ADD, 01 SUB, 10 AND, 11 OR.
- A1, B1  input  N each  requester 1 operands.
- ALUControl1  input  2  requester 1 op, same encoding.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer accept.
- rsp_id  output  1  requester that owns the response.
- Result  output  N  registered ALU result.
- V, C, Neg, Z  output  1 each  registered ALU flags.

Behaviour:
- Clock and reset: one clock domain (clk); reset_n is synchronous and active-low. All state updates on the rising edge of clk.
- Reset (reset_n=0 at an edge) forces:
  - state=IDLE, rsp_valid=0, req_ready=00;
  - rsp_id=0, Result=0, V=C=Neg=Z=0;
  - last_grant=1, so requester 0 wins the first contention.
- Reset mid-operation abandons the in-flight operation; no response is produced for it.
- State machine:
  - IDLE:
    - grant is combinational: if exactly one req_valid bit is high, grant that requester; if both are high, grant the requester != last_grant; if neither, no grant.
    - req_ready[grant]=1 only when some req_valid bit is high.
    - on handshake (req_valid[i]&req_ready[i]): latch Ai/Bi/ALUControli into op registers, set id=i, go to EXEC.
  - EXEC: req_ready=00. The ALU is driven from the op registers. At the edge, register Result/V/C/Neg/Z from the ALU outputs, set rsp_id=id and rsp_valid=1, go to RESP.
  - RESP:
    - rsp_valid=1; rsp_id, Result and flags are held stable while rsp_ready=0.
    - req_ready=00; no new request is accepted.
    - on rsp_valid&rsp_ready: rsp_valid=0, last_grant=id, go to IDLE.
- Latency and throughput:
  - request accepted at edge k gives rsp_valid=1 from edge k+1 (rsp_valid is registered in EXEC);
  - minimum of 3 cycles per operation (IDLE, EXEC, RESP), no pipelining.
- Request-side rules:
  - a requester must hold its operands stable until it sees its req_ready;
  - operands changing after acceptance have no effect on the in-flight operation;
  - a non-granted requester keeps waiting; no request is ever dropped.
- Fairness: under continuous contention grants strictly alternate 0,1,0,1.
- Flags are passed through from the ALU unmodified:
  - V = carry-out(bit 7) XOR carry-out(bit 6); C = carry-out(bit 7).
  - Neg and Z are taken from the adder sum, not from Result. For AND/OR they reflect A+B, and the adder is still active, so V and C reflect A+B as well.
  - SUB is computed as A + ~B + 1.

Test Plan:
- After reset, both requesters valid with ADD: req0 A=100, B=50; req1 A=5, B=5 op SUB, rsp_ready=1.
  - -> req_ready=01 first.
  - -> rsp_id=0, Result=0x96, V=1, C=0, Neg=1, Z=0.
  - -> next grant goes to req1: rsp_id=1, Result=0x00, C=1, Z=1, V=0, Neg=0.
- Requester 1 only, AND with A=0xF0, B=0x3C.
  - -> Result=0x30, C=1, V=0, Neg=0, Z=0 (flags from sum 0x2C).
  - -> rsp_valid rises 1 cycle after acceptance.
- Backpressure: hold rsp_ready=0 for 5 cycles during RESP with both req_valid high.
  - -> rsp_valid, Result and flags stay constant.
  - -> req_ready=00 throughout.
  - -> after rsp_ready=1, returns to IDLE and grants the other requester.
- Continuous contention with rsp_ready=1 for 6 operations -> grant sequence 0,1,0,1,0,1; every rsp_id matches the grant order.
- Drop reset_n during EXEC of OR A=0x0F, B=0xF0.
  - -> the next cycle shows all outputs 0 and state IDLE.
  - -> no response for that operation.
  - -> a fresh request from both requesters grants requester 0 first.
